// File: rtl/hazard_pkg.sv
// Shared constants for the gen2 hazard/forwarding controller.
package hazard_pkg;
  localparam int unsigned FWD_RF     = 0;
  localparam int unsigned DEF_RA_W   = 5;
  localparam int unsigned DEF_MD_LAT = 32;
  localparam int unsigned EX_STG     = 1;
  localparam int unsigned MEM_STG    = 2;
endpackage

// File: rtl/hazard_fwd_match.sv
// Per-source priority matcher: lowest (youngest) matching producer stage wins.
module hazard_fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W           = DEF_RA_W,
  parameter int unsigned FWD_STAGES     = 2,
  parameter int unsigned LOAD_READY_STG = MEM_STG,
  parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
  input  logic [RA_W-1:0]            src,
  input  logic                       used,
  input  logic [FWD_STAGES*RA_W-1:0] stg_wr,
  input  logic [FWD_STAGES-1:0]      stg_we,
  input  logic [FWD_STAGES-1:0]      stg_ld,
  output logic [SEL_W-1:0]           sel,
  output logic                       ld_hit
);

  logic [RA_W-1:0] dst;
  logic            found;

  always_comb begin
    sel    = SEL_W'(FWD_RF);
    ld_hit = 1'b0;
    found  = 1'b0;
    dst    = '0;
    for (int unsigned k = 1; k <= FWD_STAGES; k++) begin
      dst = stg_wr[k*RA_W-1 -: RA_W];
      if (!found && used && stg_we[k-1] && (dst != '0) && (dst == src)) begin
        found  = 1'b1;
        sel    = SEL_W'(k);
        ld_hit = stg_ld[k-1] && (k < LOAD_READY_STG);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl_gen2.sv
// Hazard/forwarding controller: N-stage forwarding, load-use and mul/div interlock, branch flush.
// Optional HAZARD_STATS_EN adds saturating stall_cnt/fwd_cnt outputs.
module hazard_ctrl_gen2
  import hazard_pkg::*;
#(
  parameter int unsigned RA_W           = DEF_RA_W,
  parameter int unsigned FWD_STAGES     = 2,
  parameter int unsigned LOAD_READY_STG = MEM_STG,
  parameter int unsigned MD_LAT         = DEF_MD_LAT,
  parameter int unsigned SEL_W          = $clog2(FWD_STAGES + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RA_W-1:0]            r1_id,
  input  logic [RA_W-1:0]            r2_id,
  input  logic                       r1_used,
  input  logic                       r2_used,
  input  logic                       id_valid,
  input  logic                       id_hilo_rd,
  input  logic                       id_md_start,
  input  logic [FWD_STAGES*RA_W-1:0] stg_wr,
  input  logic [FWD_STAGES-1:0]      stg_we,
  input  logic [FWD_STAGES-1:0]      stg_ld,
  input  logic                       br_taken_ex,
  output logic [SEL_W-1:0]           fwd_r1_sel,
  output logic [SEL_W-1:0]           fwd_r2_sel,
  output logic                       lock_if,
  output logic                       lock_id,
  output logic                       bubble_ex,
  output logic                       flush_id,
`ifdef HAZARD_STATS_EN
  output logic [31:0]                stall_cnt,
  output logic [31:0]                fwd_cnt,
`endif
  output logic                       md_busy
);

  localparam int unsigned MD_W = $clog2(MD_LAT + 1);

  logic            r1_ld_hit;
  logic            r2_ld_hit;
  logic            ld_stall;
  logic            md_stall;
  logic            stall;
  logic            md_load;
  logic [MD_W-1:0] md_cnt;

  hazard_fwd_match #(
    .RA_W          (RA_W),
    .FWD_STAGES    (FWD_STAGES),
    .LOAD_READY_STG(LOAD_READY_STG),
    .SEL_W         (SEL_W)
  ) u_match_r1 (
    .src   (r1_id),
    .used  (r1_used),
    .stg_wr(stg_wr),
    .stg_we(stg_we),
    .stg_ld(stg_ld),
    .sel   (fwd_r1_sel),
    .ld_hit(r1_ld_hit)
  );

  hazard_fwd_match #(
    .RA_W          (RA_W),
    .FWD_STAGES    (FWD_STAGES),
    .LOAD_READY_STG(LOAD_READY_STG),
    .SEL_W         (SEL_W)
  ) u_match_r2 (
    .src   (r2_id),
    .used  (r2_used),
    .stg_wr(stg_wr),
    .stg_we(stg_we),
    .stg_ld(stg_ld),
    .sel   (fwd_r2_sel),
    .ld_hit(r2_ld_hit)
  );

  // Stall uses the current counter value, so the cycle it reaches 0 still interlocks.
  always_comb begin
    md_busy   = (md_cnt != '0);
    ld_stall  = r1_ld_hit | r2_ld_hit;
    md_stall  = id_valid & md_busy & (id_hilo_rd | id_md_start);
    stall     = id_valid & (ld_stall | md_stall);
    lock_if   = stall & ~br_taken_ex;
    lock_id   = stall & ~br_taken_ex;
    bubble_ex = stall | br_taken_ex;
    flush_id  = br_taken_ex;
    md_load   = id_md_start & id_valid & ~stall & ~br_taken_ex;
  end

  always_ff @(posedge clk) begin
    if (rst)               md_cnt <= '0;
    else if (md_load)      md_cnt <= MD_W'(MD_LAT);
    else if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (lock_id && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (((fwd_r1_sel != '0) || (fwd_r2_sel != '0)) && !stall && (fwd_cnt != '1))
        fwd_cnt <= fwd_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: doc/hazard_ctrl_gen2.md
Name: hazard_ctrl_gen2

Overview:
- Second-generation hazard/forwarding controller for the pipelined MIPS core.
- Generalises forwarding to FWD_STAGES producer stages with a configurable load-ready stage.
- Adds a multi-cycle mul/div busy scoreboard with HI/LO interlock, and branch-taken flush.
- Sits beside the ID stage; drives the forwarding muxes, IF/ID lock, ID→EX bubble and flush.

Parameters:
- RA_W, 5, register address width.
- FWD_STAGES, 2, number of producer stages after ID (stage 1 = EX, 2 = MEM, ...).
- LOAD_READY_STG, 2, first stage index whose load data is forwardable (range 1..FWD_STAGES).
- MD_LAT, 32, mul/div occupancy in cycles (≥2).
- SEL_W, $clog2(FWD_STAGES+1), width of the forward-select codes.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- r1_id, r2_id  in  RA_W each  ID source register addresses.
- r1_used, r2_used  in  1 each  source actually read (replaces the old Shift/I_ins masking).
- id_valid  in  1  ID holds a real instruction.
- id_hilo_rd  in  1  ID instruction reads HI/LO (mfhi/mflo).
- id_md_start  in  1  ID instruction is mult/div.
- stg_wr  in  FWD_STAGES*RA_W  destination per stage; stage k at bits [k*RA_W-1 -: RA_W].
- stg_we  in  FWD_STAGES  per-stage register-write enable.
- stg_ld  in  FWD_STAGES  per-stage "is load".
- br_taken_ex  in  1  branch/jump resolved taken in EX.
- fwd_r1_sel, fwd_r2_sel  out  SEL_W each  0 = register file, k = stage k.
- lock_if, lock_id  out  1 each  hold PC and IF/ID.
- bubble_ex  out  1  insert NOP into ID/EX.
- flush_id  out  1  squash IF/ID contents.
- md_busy  out  1  mul/div unit occupied.

Behaviour:
- Match k for source s: s_used, stg_we[k], stg_wr[k] != 0, stg_wr[k] == s. Register $0 never forwards or stalls.
- fwd_sel is the lowest matching k, so the youngest producer wins; 0 if no match. Combinational.
- Load-use: matching k (the one selected) with stg_ld[k] and k < LOAD_READY_STG raises ld_stall. In that case fwd_sel is still reported; the consumer ignores it while stalled.
- md counter (ceil(log2(MD_LAT+1)) bits), registered:
  - Loads MD_LAT when id_md_start & id_valid & no stall & no flush.
  - Otherwise decrements to 0.
  - md_busy = counter != 0.
- md_stall = id_valid & md_busy & (id_hilo_rd | id_md_start).
- stall = id_valid & (ld_stall | md_stall).
- Outputs:
  - lock_if = lock_id = stall & ~br_taken_ex.
  - bubble_ex = stall | br_taken_ex.
  - flush_id = br_taken_ex.
- Simultaneous branch-taken and stall: flush wins; no lock, the ID instruction is discarded, and the md counter is not loaded.
- Counter reaching 0 and the ID mfhi arriving in the same cycle: stall is evaluated on the current (nonzero) value; the instruction proceeds the next cycle.
- Reset: counter = 0; all outputs 0 (combinational outputs follow zeroed state; stalls are gated by id_valid, which the pipeline holds low in reset). Reset mid-mul/div aborts it and md_busy drops the next cycle.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs stall_cnt[31:0] and fwd_cnt[31:0], both cleared by rst:
  - stall_cnt increments each cycle lock_id = 1.
  - fwd_cnt increments each cycle (fwd_r1_sel != 0 | fwd_r2_sel != 0) & ~stall.
  - Both saturate at all-ones.
- When undefined, these ports and their registers are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg:
  - FWD_RF = 0 select constant.
  - Default RA_W, MD_LAT.
  - Stage index constants EX_STG = 1, MEM_STG = 2.
- One sub-module, hazard_fwd_match: a per-source priority matcher producing sel and ld_hit. It is instantiated twice.

Test Plan:
- Forward priority: r1_id = 8, r1_used = 1; stg_wr = {MEM: 8, EX: 8}; stg_we = 2'b11; stg_ld = 0 → fwd_r1_sel = 1, no stall. Drop EX we → fwd_r1_sel = 2.
- $0 and unused source: r1 = 0 matching EX dest 0; r2 = 9 with r2_used = 0 matching EX dest 9 → both sel = 0, no stall.
- Load-use: EX stg_ld = 1 writing 5, r2_id = 5 → lock_if = lock_id = bubble_ex = 1 for 1 cycle. Next cycle (load now in MEM) → fwd_r2_sel = 2, stall = 0.
- Mul/div: id_md_start at cycle 0 with MD_LAT = 4 → md_busy for cycles 1–4. mfhi at cycle 2 stalls through cycle 4 and proceeds in cycle 5. A second mult at cycle 3 also stalls.
- Branch vs stall: load-use stall and br_taken_ex in the same cycle → lock = 0, bubble_ex = 1, flush_id = 1. An md_start in ID at that time does not load the counter.
- Reset mid-operation: rst asserted at counter = 17 → md_busy = 0 the next cycle; stats counters (HAZARD_STATS_EN) read 0.
